rrv_data_mem: RTL and testbench
===============================

Name: rrv_data_mem

Overview:
Parametrised single-port data memory for the RRV core's load/store unit. It replaces the word-only data RAM and adds:
- byte-addressed access with RISC-V load/store sizes (byte, half, word)
- byte-lane write enables
- sign/zero extension of loads
- misalignment and range error reporting
- a valid/ready request/response handshake with configurable read latency and response back-pressure
It sits between the MEM pipeline stage and the core's data bus.

Parameters:
DATA_WIDTH, 32, word width in bits; fixed at 32 (RV32I); elaborate-time error otherwise
DEPTH, 1024, number of words; power of two, >= 2
ADDR_WIDTH, $clog2(DEPTH)+2, byte-address width
READ_LATENCY, 1, response latency in cycles; 1 = array output only, 2 = extra output register; any other value is an elaborate-time error

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
req_unsigned  in  1  loads: zero-extend (LBU/LHU) when 1
req_wdata  in  32  store data, right-aligned (bits [7:0]/[15:0]/[31:0] used)
rsp_valid  out  1  response present (loads and stores)
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  request was misaligned, out of range, or reserved size

Behaviour:
- Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, all pipeline valid bits 0. req_ready is 1 in the cycle after rst deasserts. Memory contents are not cleared.
- Reset mid-operation: every in-flight request is dropped and no response is produced for it. A store accepted in the same cycle as rst is not written.
- Accept: a request is accepted when req_valid & req_ready.
- req_ready = !(pipeline full & rsp_valid & !rsp_ready). Data is never dropped or duplicated under back-pressure.
- Word index = req_addr[ADDR_WIDTH-1:2]; byte lane = req_addr[1:0].
- Error conditions:
  - size 1 with addr[0]=1
  - size 2 with addr[1:0]!=0
  - size 3
- Out of range: cannot occur when ADDR_WIDTH is exactly $clog2(DEPTH)+2. Any upper address bits from a wider bus are checked by the caller.
- On error: the store is suppressed (no byte is written); the response has rsp_err=1 and rsp_rdata=0.
- Store: byte enables are derived from size/lane. Data is replicated into the lane (byte into all 4 lanes, half into both halves). Only enabled bytes are written, at the accept clock edge.
  - Store response: rsp_err per the checks above, rsp_rdata=0, same latency as a load.
- Load: the array read is registered at the accept edge. Lane select and sign/zero extension are applied on the registered word.
  - byte: bits [8*lane+7 : 8*lane]
  - half: bits [16*lane[1]+15 : 16*lane[1]]
- Latency: the response is valid exactly READ_LATENCY cycles after accept when rsp_ready is held at 1. Full throughput is 1 request/cycle.
- Pipeline control: the pipeline is a valid-tagged register chain of depth READ_LATENCY carrying {we, lane, size, unsigned, err}.
  - On stall, every stage holds and the array read is not re-issued. The output stage captures and holds.
  - For READ_LATENCY=1, a holding register keeps rsp_rdata stable while rsp_valid & !rsp_ready.
- Ordering: responses are returned strictly in request order.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data; no forwarding is needed (single port, sequential).
- Simultaneous: a response handshake and a new accept in the same cycle are both permitted.

Decomposition:
- Shared package rrv_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - function byte_en(size, lane)
  - function misaligned(size, lane)
  - function load_extend(word, size, lane, unsigned)
- One sub-module, rrv_bram_be: a plain single-port array with per-byte write enable, a read enable, and registered output with hold. This keeps the array inferable as block RAM.

Test Plan:
- Reset then SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 1 cycle after accept (RL=1), rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- SH 0x1234 @0x12, then LH @0x12 -> 0x00001234; LW @0x10 -> 0x1234BEEF.
- LW @0x11, SH @0x13, size=3 -> rsp_err=1, rdata=0; a subsequent LW @0x10 is unchanged (no write occurred).
- Back-to-back LWs @0x0,0x4,0x8 with rsp_ready low for 3 cycles mid-stream (RL=1 and RL=2) -> req_ready drops, responses arrive in order, none lost or duplicated, rdata stable while stalled.
- Assert rst with 2 requests in flight (RL=2) -> rsp_valid=0 on the next cycle and no stale response afterwards; prior stored data is still readable.

Source files
------------

// File: rtl/rrv_mem_pkg.sv
// Shared types and lane/size helpers for the RRV data memory.
// Load/store size encodings follow the RISC-V funct3[1:0] field.
package rrv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_e;

    // Sideband carried alongside each request through the read pipeline.
    typedef struct packed {
        logic       we;
        logic [1:0] lane;
        logic [1:0] size;
        logic       uns;
        logic       err;
    } pipe_tag_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Reserved size is folded in here so one flag covers every rejected request.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
            SZ_HALF: r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rrv_data_mem_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface rrv_data_mem_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rrv_bram_be.sv
// Single-port word array with per-byte write enables and a read register that
// holds its value until the next read, shaped for block-RAM inference.
module rrv_bram_be #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    output logic [31:0]           rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rrv_data_mem.sv
// Byte-addressed RV32 data memory with valid/ready request and response channels,
// sign/zero-extended loads, misalignment errors and 1- or 2-cycle read latency.
module rrv_data_mem
    import rrv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH) + 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic           clk,
    input logic           rst,
    rrv_data_mem_if.slave mem_bus
);
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("rrv_data_mem: DATA_WIDTH must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rrv_data_mem: DEPTH must be a power of two >= 2");
    end
    if (ADDR_WIDTH != $clog2(DEPTH) + 2) begin : g_bad_addr
        $error("rrv_data_mem: ADDR_WIDTH must equal $clog2(DEPTH)+2");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("rrv_data_mem: READ_LATENCY must be 1 or 2");
    end

    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;

    logic [1:0]           req_lane;
    logic [IDX_WIDTH-1:0] req_idx;
    logic                 req_err;
    logic                 accept;
    logic [3:0]           wr_be;
    logic                 rd_en;
    logic [31:0]          wr_data;
    logic [31:0]          arr_rdata;
    logic [31:0]          s1_rdata;
    pipe_tag_t            req_tag;
    pipe_tag_t            s1_tag_q;
    logic                 s1_valid_q;
    logic                 s1_adv;

    always_comb begin
        req_lane = mem_bus.req_addr[1:0];
        req_idx  = mem_bus.req_addr[ADDR_WIDTH-1:2];
        req_err  = misaligned(mem_bus.req_size, req_lane);
        accept   = mem_bus.req_valid & mem_bus.req_ready;
        // A store coinciding with reset is discarded along with the pipeline.
        wr_be    = (accept && mem_bus.req_we && !req_err && !rst)
                   ? byte_en(mem_bus.req_size, req_lane) : 4'b0000;
        rd_en    = accept && !mem_bus.req_we && !req_err;
        case (mem_bus.req_size)
            SZ_BYTE: wr_data = {4{mem_bus.req_wdata[7:0]}};
            SZ_HALF: wr_data = {2{mem_bus.req_wdata[15:0]}};
            default: wr_data = mem_bus.req_wdata;
        endcase
        req_tag = '{we:   mem_bus.req_we,
                    lane: req_lane,
                    size: mem_bus.req_size,
                    uns:  mem_bus.req_unsigned,
                    err:  req_err};
    end

    rrv_bram_be #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (IDX_WIDTH)
    ) u_bram (
        .clk     (clk),
        .addr_i  (req_idx),
        .be_i    (wr_be),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .rdata_o (arr_rdata)
    );

    // Stage 1 pairs the registered array word with its request tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
        end
        if (accept) begin
            s1_tag_q <= req_tag;
        end
    end

    assign s1_rdata = (s1_tag_q.we || s1_tag_q.err) ? 32'h0
                    : load_extend(arr_rdata, s1_tag_q.size, s1_tag_q.lane, s1_tag_q.uns);

    assign mem_bus.req_ready = s1_adv;

    if (READ_LATENCY == 2) begin : g_rl2
        logic        s2_valid_q;
        logic        s2_err_q;
        logic [31:0] s2_rdata_q;
        logic        s2_adv;

        // A stage moves when it is empty or its successor is moving, so bubbles collapse.
        assign s2_adv = !s2_valid_q || mem_bus.rsp_ready;
        assign s1_adv = !s1_valid_q || s2_adv;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
            end else if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                s2_err_q   <= s1_tag_q.err;
                s2_rdata_q <= s1_rdata;
            end
        end

        assign mem_bus.rsp_valid = s2_valid_q;
        assign mem_bus.rsp_err   = s2_valid_q & s2_err_q;
        assign mem_bus.rsp_rdata = s2_valid_q ? s2_rdata_q : 32'h0;
    end else begin : g_rl1
        // The array read register holds while stalled, so it doubles as the output hold.
        assign s1_adv            = !s1_valid_q || mem_bus.rsp_ready;
        assign mem_bus.rsp_valid = s1_valid_q;
        assign mem_bus.rsp_err   = s1_valid_q & s1_tag_q.err;
        assign mem_bus.rsp_rdata = s1_valid_q ? s1_rdata : 32'h0;
    end

endmodule

// File: tb/tb_rrv_data_mem.sv
// Randomised and directed checks of rrv_data_mem at READ_LATENCY 1 and 2 against a
// byte-array reference model with an in-order response scoreboard.
module tb_rrv_data_mem;
    localparam int DEPTH = 64;
    localparam int AW    = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        logic        lit;
        logic [31:0] lit_data;
        logic        lit_err;
    } exp_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic [1:0]    rst_v;
    logic [1:0]    d_valid, d_we, d_uns, d_rdy;
    logic [AW-1:0] d_addr  [2];
    logic [1:0]    d_size  [2];
    logic [31:0]   d_wdata [2];
    logic [1:0]    o_ready, o_vld, o_err;
    logic [31:0]   o_rdata [2];
    logic [1:0]    rr_mode;
    logic [1:0]    want_lit, lit_e;
    logic [31:0]   lit_d [2];

    exp_t        fifo [2][4];
    int          head [2];
    int          cnt  [2];
    int          n_stall [2];
    logic [7:0]  mm [2][64];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    rrv_data_mem_if #(.ADDR_WIDTH(AW)) bus1 ();
    rrv_data_mem_if #(.ADDR_WIDTH(AW)) bus2 ();

    assign bus1.req_valid = d_valid[0];   assign bus2.req_valid = d_valid[1];
    assign bus1.req_we = d_we[0];         assign bus2.req_we = d_we[1];
    assign bus1.req_addr = d_addr[0];     assign bus2.req_addr = d_addr[1];
    assign bus1.req_size = d_size[0];     assign bus2.req_size = d_size[1];
    assign bus1.req_unsigned = d_uns[0];  assign bus2.req_unsigned = d_uns[1];
    assign bus1.req_wdata = d_wdata[0];   assign bus2.req_wdata = d_wdata[1];
    assign bus1.rsp_ready = d_rdy[0];     assign bus2.rsp_ready = d_rdy[1];
    assign o_ready = {bus2.req_ready, bus1.req_ready};
    assign o_vld   = {bus2.rsp_valid, bus1.rsp_valid};
    assign o_err   = {bus2.rsp_err, bus1.rsp_err};
    assign o_rdata[0] = bus1.rsp_rdata;
    assign o_rdata[1] = bus2.rsp_rdata;

    rrv_data_mem #(.DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst_v[0]), .mem_bus(bus1));
    rrv_data_mem #(.DEPTH(DEPTH), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst_v[1]), .mem_bus(bus2));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL rl%0d %s: got %08h, required %08h (cycle %0d)",
                      k + 1, name, act, exp, cyc);
    endtask

    // Push the architecturally expected response for a request accepted this cycle.
    task automatic model_accept(input int k);
        exp_t        e;
        int          a, nb;
        logic [1:0]  sz;
        logic [31:0] v;
        a  = int'(d_addr[k]);
        sz = d_size[k];
        e.err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v  = 32'h0;
        if (!e.err) begin
            for (int i = 0; i < nb; i++) begin
                if (d_we[k]) mm[k][a+i] = d_wdata[k][8*i +: 8];
                else v[8*i +: 8] = mm[k][a+i];
            end
        end
        if (!d_uns[k] && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (!d_uns[k] && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
        if (d_we[k]) v = 32'h0;
        e.data     = v;
        e.due      = cyc + k + 1;
        e.lit      = want_lit[k];
        e.lit_data = lit_d[k];
        e.lit_err  = lit_e[k];
        fifo[k][(head[k] + cnt[k]) % 4] = e;
        cnt[k]++;
    endtask

    task automatic mon(input int k);
        logic exp_v, exp_rdy;
        exp_t f;
        if (rst_v[k]) begin
            cnt[k]  = 0;
            head[k] = 0;
        end else begin
            f       = fifo[k][head[k]];
            exp_v   = (cnt[k] > 0) && (f.due <= cyc);
            exp_rdy = !(cnt[k] == k + 1 && exp_v && !d_rdy[k]);
            chk(k, "rsp_valid", {31'b0, o_vld[k]}, {31'b0, exp_v});
            chk(k, "req_ready", {31'b0, o_ready[k]}, {31'b0, exp_rdy});
            if (!o_ready[k]) n_stall[k]++;
            if (exp_v && o_vld[k]) begin
                chk(k, "rsp_rdata", o_rdata[k], f.data);
                chk(k, "rsp_err", {31'b0, o_err[k]}, {31'b0, f.err});
                if (f.lit && d_rdy[k]) begin
                    chk(k, "lit_rdata", o_rdata[k], f.lit_data);
                    chk(k, "lit_err", {31'b0, o_err[k]}, {31'b0, f.lit_err});
                end
                if (d_rdy[k]) begin
                    head[k] = (head[k] + 1) % 4;
                    cnt[k]--;
                end
            end
            if (d_valid[k] && o_ready[k]) model_accept(k);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) mon(k);
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (rr_mode[k]) d_rdy[k] = ($urandom_range(2) != 0);
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input int k, input logic we, input int addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input logic lit,
                         input logic [31:0] ld, input logic le);
        int   w;
        logic acc;
        d_we[k] = we;  d_addr[k] = addr[AW-1:0];  d_size[k] = size;
        d_uns[k] = uns;  d_wdata[k] = wd;
        want_lit[k] = lit;  lit_d[k] = ld;  lit_e[k] = le;
        d_valid[k] = 1'b1;
        w = 0;
        acc = 1'b0;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = o_ready[k];
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) begin
            n_tot++;
            $display("FAIL rl%0d accept_timeout: got req_ready low for 50 cycles, required accept",
                     k + 1);
        end
        d_valid[k]  = 1'b0;
        want_lit[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int w;
        w = 0;
        while (cnt[k] != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (cnt[k] != 0) begin
            n_tot++;
            $display("FAIL rl%0d drain_timeout: got %0d responses outstanding, required 0",
                     k + 1, cnt[k]);
        end
    endtask

    task automatic run(input int k);
        int sel, gap;
        for (int w = 0; w < 16; w++) issue(k, 1, 4 * w, 2, 0, 32'hC0DE0000 | w, 0, 0, 0);
        drain(k);
        issue(k, 1, 'h10, 2, 0, 32'hDEADBEEF, 1, 32'h0, 0);
        issue(k, 0, 'h10, 2, 0, 0, 1, 32'hDEADBEEF, 0);
        issue(k, 1, 'h13, 0, 0, 32'h00000080, 1, 32'h0, 0);
        issue(k, 0, 'h13, 0, 0, 0, 1, 32'hFFFFFF80, 0);
        issue(k, 0, 'h13, 0, 1, 0, 1, 32'h00000080, 0);
        issue(k, 0, 'h10, 2, 0, 0, 1, 32'h80ADBEEF, 0);
        issue(k, 1, 'h12, 1, 0, 32'h00001234, 1, 32'h0, 0);
        issue(k, 0, 'h12, 1, 0, 0, 1, 32'h00001234, 0);
        issue(k, 0, 'h10, 2, 0, 0, 1, 32'h1234BEEF, 0);
        issue(k, 0, 'h11, 2, 0, 0, 1, 32'h0, 1);
        issue(k, 1, 'h13, 1, 0, 32'h0000FFFF, 1, 32'h0, 1);
        issue(k, 1, 'h10, 3, 0, 32'h00000000, 1, 32'h0, 1);
        issue(k, 0, 'h10, 2, 0, 0, 1, 32'h1234BEEF, 0);
        drain(k);
        n_stall[k] = 0;
        fork
            begin
                issue(k, 0, 'h0, 2, 0, 0, 1, 32'hC0DE0000, 0);
                issue(k, 0, 'h4, 2, 0, 0, 1, 32'hC0DE0001, 0);
                issue(k, 0, 'h8, 2, 0, 0, 1, 32'hC0DE0002, 0);
            end
            begin
                @(posedge clk);
                #1;
                d_rdy[k] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                d_rdy[k] = 1'b1;
            end
        join
        drain(k);
        chk(k, "ready_dropped", {31'b0, n_stall[k] > 0}, 32'h1);
        // Two loads in flight, then reset while a store is presented.
        issue(k, 0, 'h0, 2, 0, 0, 0, 0, 0);
        issue(k, 0, 'h4, 2, 0, 0, 0, 0, 0);
        d_we[k] = 1'b1;  d_addr[k] = 8'h20;  d_size[k] = 2'd2;  d_wdata[k] = 32'hBAD0BAD0;
        d_valid[k] = 1'b1;
        rst_v[k] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[k] = 1'b0;
        d_valid[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        issue(k, 0, 'h20, 2, 0, 0, 1, 32'hC0DE0008, 0);
        issue(k, 0, 'h10, 2, 0, 0, 1, 32'h1234BEEF, 0);
        drain(k);
        rr_mode[k] = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(9);
            issue(k, 1'($urandom_range(1)), $urandom_range(63),
                  (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3,
                  1'($urandom_range(1)), $urandom, 0, 0, 0);
            gap = $urandom_range(3);
            if (gap == 3) begin
                @(posedge clk);
                #1;
            end
        end
        rr_mode[k] = 1'b0;
        d_rdy[k] = 1'b1;
        drain(k);
    endtask

    initial begin
        rst_v = 2'b11;  d_valid = '0;  d_we = '0;  d_uns = '0;  d_rdy = 2'b11;
        rr_mode = '0;  want_lit = '0;  lit_e = '0;
        for (int k = 0; k < 2; k++) begin
            d_addr[k] = '0;  d_size[k] = '0;  d_wdata[k] = '0;  lit_d[k] = '0;
            head[k] = 0;  cnt[k] = 0;  n_stall[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "reset_rsp_valid", {31'b0, o_vld[k]}, 32'h0);
            chk(k, "reset_rsp_rdata", o_rdata[k], 32'h0);
            chk(k, "reset_rsp_err", {31'b0, o_err[k]}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_v = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k, "ready_after_reset", {31'b0, o_ready[k]}, 32'h1);
        @(posedge clk);
        #1;
        run(0);
        run(1);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by 40000 cycles, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
